// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter port bundle: EX and SLB producer handshakes plus the CDB broadcast.
// master = producer/consumer side (bench or core), slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int NICK_W = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              iEX_en;
  logic [NICK_W-1:0] iEX_nick;
  logic [DATA_W-1:0] iEX_dt;
  logic              iEX_ac;
  logic [ADDR_W-1:0] iEX_j_pc;
  logic              oEX_ready;
  logic              iSLB_en;
  logic [NICK_W-1:0] iSLB_nick;
  logic [DATA_W-1:0] iSLB_dt;
  logic              oSLB_ready;
  logic              oCDB_en;
  logic              oCDB_src;
  logic [NICK_W-1:0] oCDB_nick;
  logic [DATA_W-1:0] oCDB_dt;
  logic              oCDB_ac;
  logic [ADDR_W-1:0] oCDB_j_pc;
  logic              oERR;

  modport master (
    output iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc, iSLB_en, iSLB_nick, iSLB_dt,
    input  oEX_ready, oSLB_ready, oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oERR
  );
  modport slave (
    input  iEX_en, iEX_nick, iEX_dt, iEX_ac, iEX_j_pc, iSLB_en, iSLB_nick, iSLB_dt,
    output oEX_ready, oSLB_ready, oCDB_en, oCDB_src, oCDB_nick, oCDB_dt, oCDB_ac, oCDB_j_pc, oERR
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter between EX and SLB, one small result FIFO per source with an
// empty-FIFO bypass so an uncontended result reaches the bus one edge after it is presented.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           rd_q, wr_q;
  logic [CW-1:0]           cnt_q, cnt_d;

  assign cnt_d   = cnt_q + CW'(push_i) - CW'(pop_i);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NICK_W = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iclr,
  cdb_arbiter_if.slave bus
);
  localparam int NSRC = 2;
  localparam int CW   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
    logic              ac;
    logic [ADDR_W-1:0] j_pc;
  } ent_t;
  localparam int EW = $bits(ent_t);

  logic [NSRC-1:0]         in_en, ready, fifo_nz, cand, gnt, byp, push, pop;
  ent_t [NSRC-1:0]         in_ent, head;
  logic [NSRC-1:0][CW-1:0] cnt;
  logic                    go, clr, gsrc, any_gnt;
  ent_t                    sel_ent;

  logic cdb_en_q, cdb_src_q, last_q, err_q;
  logic cdb_en_d, cdb_src_d, last_d, err_d;
  ent_t cdb_q, cdb_d;

  assign go  = rdy & ~iclr;
  assign clr = rdy & iclr;

  assign in_en     = {bus.iSLB_en, bus.iEX_en};
  assign in_ent[0] = '{nick: bus.iEX_nick, dt: bus.iEX_dt, ac: bus.iEX_ac, j_pc: bus.iEX_j_pc};
  assign in_ent[1] = '{nick: bus.iSLB_nick, dt: bus.iSLB_dt, ac: 1'b0, j_pc: '0};

  // Source 0 = EX, source 1 = SLB; ready looks only at the registered count.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr),
      .push_i (push[g]),
      .pop_i  (pop[g]),
      .din_i  (in_ent[g]),
      .head_o (head[g]),
      .count_o(cnt[g])
    );
    assign ready[g]   = cnt[g] < CW'(DEPTH);
    assign fifo_nz[g] = |cnt[g];
    assign cand[g]    = fifo_nz[g] | in_en[g];
    assign byp[g]     = gnt[g] & ~fifo_nz[g];
    assign push[g]    = go & in_en[g] & ready[g] & ~byp[g];
    assign pop[g]     = go & gnt[g] & fifo_nz[g];
  end

  always_comb begin
    gnt = '0;
    case (cand)
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = '0;
    endcase
  end

  assign any_gnt = |gnt;
  assign gsrc    = gnt[1];
  assign sel_ent = fifo_nz[gsrc] ? head[gsrc] : in_ent[gsrc];

  // Flush and freeze both force a bubble; payload fields hold so only en matters downstream.
  always_comb begin
    cdb_en_d  = 1'b0;
    cdb_src_d = cdb_src_q;
    cdb_d     = cdb_q;
    last_d    = last_q;
    err_d     = err_q;
    if (go) begin
      cdb_en_d = any_gnt;
      if (any_gnt) begin
        cdb_src_d = gsrc;
        cdb_d     = sel_ent;
        last_d    = gsrc;
      end
      if (|(in_en & ~ready)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_en_q  <= 1'b0;
      cdb_src_q <= 1'b0;
      cdb_q     <= '0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      cdb_en_q  <= cdb_en_d;
      cdb_src_q <= cdb_src_d;
      cdb_q     <= cdb_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign bus.oEX_ready  = ready[0];
  assign bus.oSLB_ready = ready[1];
  assign bus.oCDB_en    = cdb_en_q;
  assign bus.oCDB_src   = cdb_src_q;
  assign bus.oCDB_nick  = cdb_q.nick;
  assign bus.oCDB_dt    = cdb_q.dt;
  assign bus.oCDB_ac    = cdb_q.ac;
  assign bus.oCDB_j_pc  = cdb_q.j_pc;
  assign bus.oERR       = err_q;
endmodule
